// File: rtl/z80_paging_mmu_if.sv
// rtl/z80_paging_mmu_if.sv - Z80 control strobes, CPU address and translated RAM address.
interface z80_paging_mmu_if;
  logic        nMREQ;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        nM1;
  logic [15:0] cpu_addr;
  logic [19:0] ram_addr;

  modport master (
    output nMREQ, nIORQ, nRD, nWR, nM1, cpu_addr,
    input  ram_addr
  );

  modport slave (
    input  nMREQ, nIORQ, nRD, nWR, nM1, cpu_addr,
    output ram_addr
  );
endinterface

// File: rtl/z80_paging_mmu.sv
// rtl/z80_paging_mmu.sv - 16 x 4 KB page-register MMU and data-bus bridge for a Z80.
module z80_paging_mmu #(
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic              CLK,
  input  logic              nRESET,
  z80_paging_mmu_if.slave   bus,
  inout  wire  [7:0]        cpu_data,
  inout  wire  [7:0]        ram_data
);

  logic [7:0] pr_q [16];
  logic [7:0] pr_d;
  logic [3:0] pr_idx;

  logic mem_sel;
  logic mem_wr;
  logic mem_rd;
  logic port_hit;
  logic io_sel;
  logic io_wr;
  logic io_rd;

  logic       cpu_oe;
  logic       ram_oe;
  logic [7:0] cpu_out;

  // Memory cycles win over I/O; interrupt acknowledge (nM1 low) never touches the registers.
  assign mem_sel  = !bus.nMREQ;
  assign mem_wr   = mem_sel && !bus.nWR && bus.nRD;
  assign mem_rd   = mem_sel && !bus.nRD && bus.nWR;
  assign port_hit = (bus.cpu_addr[7:4] == IO_BASE[7:4]);
  assign io_sel   = !bus.nIORQ && bus.nM1 && bus.nMREQ && port_hit;
  assign io_wr    = io_sel && !bus.nWR;
  assign io_rd    = io_sel && !bus.nRD && bus.nWR;

  assign pr_idx = bus.cpu_addr[3:0];
  assign pr_d   = cpu_data;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 0; i < 16; i++) begin
        pr_q[i] <= 8'(i);
      end
    end else if (io_wr) begin
      pr_q[pr_idx] <= pr_d;
    end
  end

  assign bus.ram_addr = {pr_q[bus.cpu_addr[15:12]], bus.cpu_addr[11:0]};

  always_comb begin
    cpu_oe  = 1'b0;
    ram_oe  = 1'b0;
    cpu_out = 8'h00;
    if (mem_rd) begin
      cpu_oe  = 1'b1;
      cpu_out = ram_data;
    end else if (mem_wr) begin
      ram_oe  = 1'b1;
    end else if (io_rd) begin
      cpu_oe  = 1'b1;
      cpu_out = pr_q[pr_idx];
    end
  end

  assign cpu_data = cpu_oe ? cpu_out  : 8'hzz;
  assign ram_data = ram_oe ? cpu_data : 8'hzz;

endmodule

// File: tb/tb_z80_paging_mmu.sv
// tb/tb_z80_paging_mmu.sv - Scoreboard bench for the Z80 paging MMU.
module tb_z80_paging_mmu;

  logic CLK = 1'b0;
  logic nRESET;
  always #5 CLK = ~CLK;

  z80_paging_mmu_if bus ();

  logic [7:0] cpu_drv;
  logic       cpu_en;
  logic [7:0] ram_drv;
  logic       ram_en;
  wire  [7:0] cpu_data;
  wire  [7:0] ram_data;

  assign cpu_data = cpu_en ? cpu_drv : 8'hzz;
  assign ram_data = ram_en ? ram_drv : 8'hzz;

  z80_paging_mmu #(.IO_BASE(8'hF0)) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .bus      (bus),
    .cpu_data (cpu_data),
    .ram_data (ram_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q [$];
  logic [19:0] exp_v;
  logic [19:0] got_v;

  task automatic set_idle();
    bus.nMREQ = 1'b1;
    bus.nIORQ = 1'b1;
    bus.nRD   = 1'b1;
    bus.nWR   = 1'b1;
    bus.nM1   = 1'b1;
    cpu_en    = 1'b0;
    ram_en    = 1'b0;
    cpu_drv   = 8'h00;
    ram_drv   = 8'h00;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] val, input int cycles);
    @(negedge CLK);
    set_idle();
    bus.nIORQ    = 1'b0;
    bus.nWR      = 1'b0;
    bus.cpu_addr = {8'h00, port};
    cpu_drv      = val;
    cpu_en       = 1'b1;
    repeat (cycles) @(posedge CLK);
    @(negedge CLK);
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    bus.cpu_addr = 16'h0000;
    nRESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    exp_q.push_back(20'h01234);
    bus.cpu_addr = 16'h1234;
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_identity_1234 got %h expected %h", got_v, exp_v);
    end
    exp_q.push_back(20'h0F00F);
    bus.cpu_addr = 16'hF00F;
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_identity_F00F got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_remap();
    io_write(8'hF3, 8'hA5, 3);
    exp_q.push_back(20'hA5ABC);
    bus.cpu_addr = 16'h3ABC;
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL remap_page3 got %h expected %h", got_v, exp_v);
    end
    exp_q.push_back(20'h02ABC);
    bus.cpu_addr = 16'h2ABC;
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL remap_page2_untouched got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_readback();
    @(negedge CLK);
    set_idle();
    bus.nIORQ = 1'b0; bus.nRD = 1'b0;
    bus.cpu_addr = 16'h12F3;
    exp_q.push_back(20'h000A5);
    #1;
    got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL io_read_F3 got %h expected %h", got_v, exp_v);
    end
    // A released bus reads back whatever the bench itself drives onto it.
    bus.cpu_addr = 16'h0010;
    for (int p = 0; p < 2; p++) begin
      cpu_drv = (p == 0) ? 8'h00 : 8'hFF;
      cpu_en  = 1'b1;
      exp_q.push_back({12'h0, cpu_drv});
      #1;
      got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL io_read_port10_released got %h expected %h", got_v, exp_v);
      end
    end
    @(negedge CLK);
    set_idle();
    bus.nIORQ = 1'b0; bus.nM1 = 1'b0; bus.nWR = 1'b0;
    bus.cpu_addr = 16'h00F3;
    cpu_drv = 8'h11; cpu_en = 1'b1;
    exp_q.push_back(20'h00011);
    #1;
    got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL intack_no_drive got %h expected %h", got_v, exp_v);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    set_idle();
    bus.cpu_addr = 16'h3000;
    exp_q.push_back(20'hA5000);
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL intack_pr3_unchanged got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_bridge();
    @(negedge CLK);
    set_idle();
    bus.nMREQ = 1'b0; bus.nWR = 1'b0;
    bus.cpu_addr = 16'h4000;
    cpu_drv = 8'h5A; cpu_en = 1'b1;
    exp_q.push_back(20'h0005A);
    exp_q.push_back(20'h0005A);
    #1;
    got_v = {12'h0, ram_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL mem_write_ram_data got %h expected %h", got_v, exp_v);
    end
    got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL mem_write_cpu_undriven got %h expected %h", got_v, exp_v);
    end
    @(negedge CLK);
    set_idle();
    bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    ram_drv = 8'hC3; ram_en = 1'b1;
    exp_q.push_back(20'h000C3);
    exp_q.push_back(20'h000C3);
    #1;
    got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL mem_read_cpu_data got %h expected %h", got_v, exp_v);
    end
    got_v = {12'h0, ram_data}; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL mem_read_ram_undriven got %h expected %h", got_v, exp_v);
    end
    // Idle, then nRD and nWR both low: both buses must stay released.
    for (int m = 0; m < 2; m++) begin
      @(negedge CLK);
      set_idle();
      if (m == 1) begin
        bus.nMREQ = 1'b0; bus.nRD = 1'b0; bus.nWR = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        cpu_drv = (p == 0) ? 8'h00 : 8'hFF; cpu_en = 1'b1;
        ram_drv = (p == 0) ? 8'hFF : 8'h00; ram_en = 1'b1;
        exp_q.push_back({12'h0, cpu_drv});
        exp_q.push_back({12'h0, ram_drv});
        #1;
        got_v = {12'h0, cpu_data}; exp_v = exp_q.pop_front(); n_checks++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL released_cpu_bus mode %0d got %h expected %h", m, got_v, exp_v);
        end
        got_v = {12'h0, ram_data}; exp_v = exp_q.pop_front(); n_checks++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL released_ram_bus mode %0d got %h expected %h", m, got_v, exp_v);
        end
      end
    end
    @(negedge CLK);
    set_idle();
  endtask

  task automatic test_mem_priority();
    @(negedge CLK);
    set_idle();
    bus.nMREQ = 1'b0; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
    bus.cpu_addr = 16'h00F3;
    cpu_drv = 8'h99; cpu_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    set_idle();
    bus.cpu_addr = 16'h3123;
    exp_q.push_back(20'hA5123);
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL mem_priority_no_io_write got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge CLK);
    set_idle();
    nRESET = 1'b0;
    bus.nIORQ = 1'b0; bus.nWR = 1'b0;
    bus.cpu_addr = 16'h00F0;
    cpu_drv = 8'h77; cpu_en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    set_idle();
    bus.cpu_addr = 16'h0100;
    exp_q.push_back(20'h00100);
    exp_q.push_back(20'h03ABC);
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_over_write got %h expected %h", got_v, exp_v);
    end
    bus.cpu_addr = 16'h3ABC;
    #1;
    got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL reset_restores_pr3 got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      io_write(8'hF0 + 8'(i), 8'hF0 + 8'(i), 1);
    end
    for (int i = 0; i < 16; i++) begin
      bus.cpu_addr = {4'(i), 12'hFFF};
      exp_q.push_back({8'hF0 + 8'(i), 12'hFFF});
      #1;
      got_v = bus.ram_addr; exp_v = exp_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL sweep_page %0d got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    nRESET = 1'b0;
    bus.cpu_addr = 16'h0000;
    set_idle();
    test_reset();
    test_remap();
    test_readback();
    test_bridge();
    test_mem_priority();
    test_reset_priority();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_paging_mmu.md
Name: z80_paging_mmu

Overview:
- Memory-management unit between the Z80 core bus and external RAM.
- Translates the 16-bit CPU address into a 20-bit physical address through 16 programmable 4 KB page registers.
- Bridges the bidirectional data bus between the CPU and RAM.
- Page registers are written and read back through Z80 I/O cycles.

Parameters:
- IO_BASE, 8'hF0, I/O port base; low nibble must be 0. Ports IO_BASE..IO_BASE+15 map to page registers 0..15.

Ports:
- CLK  in  1  system clock; all register updates on the rising edge.
- nRESET  in  1  synchronous, active-low reset.
- nMREQ  in  1  CPU memory request, active low.
- nIORQ  in  1  CPU I/O request, active low.
- nRD  in  1  CPU read strobe, active low.
- nWR  in  1  CPU write strobe, active low.
- nM1  in  1  CPU opcode-fetch / interrupt-acknowledge, active low.
- cpu_addr  in  16  CPU address bus.
- cpu_data  inout  8  CPU data bus.
- ram_data  inout  8  RAM data bus.
- ram_addr  out  20  physical RAM address.

Behaviour:
- State is 16 page registers PR[0..15], 8 bits each.
- Reset is synchronous:
  - On a rising CLK edge with nRESET=0, PR[i] <= i (identity map), so physical = {4'h0, cpu_addr}.
  - Reset overrides any simultaneous register write.
  - Reset is also applied mid-cycle.
- Translation (combinational, always active, independent of strobes): ram_addr = {PR[cpu_addr[15:12]], cpu_addr[11:0]}.
- Memory write (nMREQ=0, nWR=0, nRD=1):
  - ram_data driven with cpu_data.
  - cpu_data not driven by this block.
- Memory read (nMREQ=0, nRD=0, nWR=1):
  - cpu_data driven with ram_data.
  - ram_data not driven.
- Page-register write:
  - Condition: nIORQ=0, nWR=0, nM1=1, nMREQ=1, cpu_addr[7:4]==IO_BASE[7:4].
  - On each rising CLK edge while the condition holds, PR[cpu_addr[3:0]] <= cpu_data.
  - A multi-cycle I/O write rewrites the same value, which is harmless.
  - cpu_addr[15:8] are ignored.
- Page-register read:
  - Condition: nIORQ=0, nRD=0, nM1=1, nMREQ=1, port match.
  - Combinationally drive cpu_data = PR[cpu_addr[3:0]].
- I/O cycles to non-matching ports: no drive, no state change.
- Interrupt acknowledge (nIORQ=0, nM1=0): no drive, no write, whatever the address.
- Idle, or nRD and nWR both low: both data buses released (high-Z).
- Never drive both cpu_data and ram_data in the same cycle.
- Never drive cpu_data during a CPU write.
- If nMREQ and nIORQ are both low, the memory path takes priority and I/O access is suppressed.
- A new mapping takes effect on ram_addr in the cycle after the write edge.
- Translation uses the current PR contents; there is no pipelining.

Test Plan:
- Reset identity: hold nRESET=0 for 2 clocks, release; cpu_addr=16'h1234 -> ram_addr=20'h01234; cpu_addr=16'hF00F -> ram_addr=20'h0F00F.
- Remap: I/O write 8'hA5 to port 8'hF3 (nIORQ=0, nWR=0, nM1=1) for 3 clocks; then cpu_addr=16'h3ABC -> ram_addr=20'hA5ABC; cpu_addr=16'h2ABC still -> 20'h02ABC.
- Readback and interrupt-acknowledge guard:
  - I/O read of port 8'hF3 -> cpu_data=8'hA5.
  - I/O read of port 8'h10 -> cpu_data high-Z.
  - Cycle with nIORQ=0, nM1=0, port 8'hF3 -> no drive, PR[3] unchanged.
- Data bridging:
  - Memory write with cpu_data=8'h5A -> ram_data=8'h5A, cpu_data not driven.
  - Memory read with RAM presenting 8'hC3 -> cpu_data=8'hC3.
  - Idle -> both buses high-Z.
- Reset priority: issue an I/O write of 8'h77 to port 8'hF0 in the same clock as nRESET=0 -> PR[0]=8'h00; cpu_addr=16'h0100 -> ram_addr=20'h00100.
- Full-map sweep: write PR[i]=8'hF0+i for all 16 pages; check cpu_addr={i,12'hFFF} -> ram_addr={8'hF0+i,12'hFFF} for every i, including wrap to 20'hFFFFF at i=15.
